// File: rtl/instr_issue_if.sv
// instr_issue_if: host write port, run/flush controls and pipeline-facing issue outputs.
interface instr_issue_if #(
    parameter int DEPTH = 16
);
    logic                   wr_valid;
    logic [31:0]            wr_instr;
    logic                   wr_ready;
    logic                   run;
    logic                   flush;
    logic [31:0]            instr;
    logic                   issue_valid;
    logic                   bubble;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]            issued_count;
    logic [15:0]            stall_count;
    modport master (
        output wr_valid, wr_instr, run, flush,
        input  wr_ready, instr, issue_valid, bubble, fifo_count, issued_count, stall_count
    );
    modport slave (
        input  wr_valid, wr_instr, run, flush,
        output wr_ready, instr, issue_valid, bubble, fifo_count, issued_count, stall_count
    );
endinterface

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program FIFO feeding a 4-stage core, with RAW-hazard bubble insertion.
module instr_issue_unit #(
    parameter int          DEPTH         = 16,
    parameter int          HAZARD_WINDOW = 3,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_007F
) (
    input logic          clk,
    input logic          rst,
    instr_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]              mem_q [DEPTH];
    logic [AW-1:0]            rd_ptr_q, wr_ptr_q;
    logic [AW:0]              count_q, count_d;
    logic [HAZARD_WINDOW-1:0] hv_q, match;
    logic [4:0]               hrd_q [HAZARD_WINDOW];
    logic [31:0]              instr_q, head;
    logic                     valid_q, bubble_q;
    logic [15:0]              issued_q, stall_q;
    logic [6:0]               op;
    logic [4:0]               rs1, rs2;
    logic                     empty, hazard, issue, stall, push, writer;

    assign head   = mem_q[rd_ptr_q];
    assign op     = head[6:0];
    assign rs1    = head[15:11];
    assign rs2    = head[20:16];
    assign writer = op == 7'd0 || op == 7'd1 || op == 7'd2 || op == 7'd4;

    for (genvar i = 0; i < HAZARD_WINDOW; i++) begin : g_haz
        assign match[i] = hv_q[i] && (hrd_q[i] == rs1 || hrd_q[i] == rs2);
    end

    assign hazard = |match;
    assign empty  = count_q == '0;
    assign stall  = bus.run && !empty && hazard;
    assign issue  = bus.run && !empty && !hazard;
    // Full refuses writes even when a pop happens in the same cycle.
    assign bus.wr_ready = count_q < (AW+1)'(DEPTH) && !bus.flush;
    assign push         = bus.wr_valid && bus.wr_ready;

    always_comb count_d = count_q + (AW+1)'(push) - (AW+1)'(issue);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_instr;
    end

    always_ff @(posedge clk) begin
        hrd_q[0] <= rs1;
        for (int i = 1; i < HAZARD_WINDOW; i++) hrd_q[i] <= hrd_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hv_q     <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (issue) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            hv_q[0]  <= issue && writer;
            for (int i = 1; i < HAZARD_WINDOW; i++) hv_q[i] <= hv_q[i-1];
            instr_q  <= issue ? head : NOP_INSTR;
            valid_q  <= issue;
            bubble_q <= stall;
        end
    end

    // Counters survive flush and saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else if (!bus.flush) begin
            if (issue && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
            if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.instr        = instr_q;
    assign bus.issue_valid  = valid_q;
    assign bus.bubble       = bubble_q;
    assign bus.fifo_count   = count_q;
    assign bus.issued_count = issued_q;
    assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: directed and random stimulus against a queue-based reference model.
module tb_instr_issue_unit;
    localparam int          DEPTH = 16;
    localparam int          HW    = 3;
    localparam logic [31:0] NOP   = 32'h0000_007F;

    logic clk = 1'b0;
    logic rst, rst_sat;
    always #5 clk = ~clk;

    instr_issue_if #(.DEPTH(DEPTH)) bus ();
    instr_issue_if #(.DEPTH(DEPTH)) sbus ();

    instr_issue_unit #(.DEPTH(DEPTH), .HAZARD_WINDOW(HW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    instr_issue_unit #(.DEPTH(DEPTH), .HAZARD_WINDOW(4), .NOP_INSTR(NOP)) sat (
        .clk(clk), .rst(rst_sat), .bus(sbus));

    int n_tests = 0, n_fail = 0;
    logic [31:0] q[$];
    int hist[$];
    logic [31:0] e_instr = NOP;
    logic e_v = 1'b0, e_b = 1'b0;
    int e_iss = 0, e_stl = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_writer(input logic [31:0] w);
        return w[6:0] == 7'd0 || w[6:0] == 7'd1 || w[6:0] == 7'd2 || w[6:0] == 7'd4;
    endfunction

    task automatic drive(input bit wv, input logic [31:0] w, input bit r, input bit f);
        bus.wr_valid = wv;
        bus.wr_instr = w;
        bus.run      = r;
        bus.flush    = f;
    endtask

    // Model one clock of the issue unit from the current inputs, then compare.
    task automatic tick();
        logic [31:0] h;
        bit haz;
        int sz, slot;
        sz = q.size();
        if (rst) begin
            q.delete(); hist.delete();
            e_iss = 0; e_stl = 0; e_instr = NOP; e_v = 0; e_b = 0;
        end else if (bus.flush) begin
            q.delete(); hist.delete();
            e_instr = NOP; e_v = 0; e_b = 0;
        end else begin
            haz = 0; slot = -1;
            h = (sz > 0) ? q[0] : NOP;
            foreach (hist[i])
                if (hist[i] >= 0 && (hist[i] == int'(h[15:11]) || hist[i] == int'(h[20:16]))) haz = 1;
            e_instr = NOP; e_v = 0; e_b = 0;
            if (bus.run && sz > 0 && !haz) begin
                e_instr = h; e_v = 1;
                void'(q.pop_front());
                if (e_iss < 65535) e_iss++;
                if (is_writer(h)) slot = int'(h[15:11]);
            end else if (bus.run && sz > 0) begin
                e_b = 1;
                if (e_stl < 65535) e_stl++;
            end
            hist.push_front(slot);
            if (hist.size() > HW) void'(hist.pop_back());
            if (bus.wr_valid && sz < DEPTH) q.push_back(bus.wr_instr);
        end
        @(posedge clk);
        #1;
        chk("instr", bus.instr, e_instr);
        chk("issue_valid", bus.issue_valid, e_v);
        chk("bubble", bus.bubble, e_b);
        chk("fifo_count", bus.fifo_count, q.size());
        chk("wr_ready", bus.wr_ready, q.size() < DEPTH && !bus.flush);
        chk("issued_count", bus.issued_count, e_iss);
        chk("stall_count", bus.stall_count, e_stl);
    endtask

    initial begin
        logic [31:0] w, hz[3];
        bit ev[5], eb[5];
        int nv, sel, cnt;
        hz = '{32'h0001_1800, 32'h0002_2000, 32'h0003_2802};
        ev = '{1, 1, 0, 0, 1};
        eb = '{0, 0, 1, 1, 0};
        sbus.wr_valid = 1'b1;
        sbus.wr_instr = 32'h0005_2800;
        sbus.run      = 1'b1;
        sbus.flush    = 1'b0;
        rst_sat = 1'b1;
        rst = 1'b1;
        drive(1, hz[0], 0, 0);
        tick();
        tick();
        rst_sat = 1'b0;
        rst = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        chk("reset_nothing_queued", bus.fifo_count, 0);
        chk("reset_nop", bus.instr, NOP);

        for (int i = 0; i < 3; i++) begin drive(1, hz[i], 0, 0); tick(); end
        drive(0, 0, 1, 0);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("hazard_valid_seq", bus.issue_valid, ev[t]);
            chk("hazard_bubble_seq", bus.bubble, eb[t]);
        end
        chk("hazard_stalls", bus.stall_count, 2);
        chk("hazard_issued", bus.issued_count, 3);

        for (int k = 0; k <= 16; k++) begin
            if (k == 16) chk("full_wr_ready", bus.wr_ready, 0);
            drive(1, (32'(k) << 11) | (32'(k + 16) << 16), 0, 0);
            tick();
        end
        chk("seventeenth_refused", bus.fifo_count, 16);
        drive(0, 0, 1, 0);
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            nv += int'(bus.issue_valid);
            chk("stream_order", bus.instr, (32'(k) << 11) | (32'(k + 16) << 16));
        end
        chk("stream_issues", nv, 16);
        chk("stream_no_bubbles", bus.stall_count, 2);

        for (int k = 0; k < 16; k++) begin
            drive(1, (32'(k) << 11) | (32'(k + 16) << 16), 0, 0);
            tick();
        end
        drive(1, 32'hABC0_0003, 1, 0);
        tick();
        chk("full_pop_refused", bus.fifo_count, 15);
        drive(1, 32'hABC0_0003, 0, 0);
        tick();
        chk("full_pop_next_accept", bus.fifo_count, 16);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick();

        drive(1, 32'h0000_3000, 0, 0); tick();
        drive(1, 32'h0006_3801, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin drive(1, (32'(i + 8) << 11) | 32'h0009_0003, 0, 0); tick(); end
        drive(0, 0, 1, 0);
        tick();
        chk("flush_pre_count", bus.fifo_count, 5);
        drive(1, 32'h0000_0000, 1, 1);
        tick();
        chk("flush_count", bus.fifo_count, 0);
        chk("flush_nop", bus.instr, NOP);
        drive(0, 0, 1, 0);
        nv = 0;
        for (int i = 0; i < 4; i++) begin tick(); nv += int'(bus.issue_valid); end
        chk("flush_no_issue", nv, 0);

        for (int i = 0; i < 4; i++) begin drive(1, 32'h0000_0803 | (32'(i) << 11), 0, 0); tick(); end
        drive(0, 0, 1, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midreset_count", bus.fifo_count, 0);
        chk("midreset_issued", bus.issued_count, 0);

        for (int i = 0; i < 800; i++) begin
            w = $urandom;
            sel = $urandom_range(0, 6);
            w[6:0] = (sel == 0) ? 7'd0 : (sel == 1) ? 7'd1 : (sel == 2) ? 7'd2 :
                     (sel == 3) ? 7'd4 : (sel == 4) ? 7'd3 : (sel == 5) ? 7'h7F : 7'd5;
            w[15:11] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 1) == 1, w, $urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0);
            rst = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);

        cnt = 0;
        while (cnt < 90000 && sbus.stall_count !== 16'hFFFF) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("sat_reached", sbus.stall_count, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
        chk("sat_held", sbus.stall_count, 16'hFFFF);
        chk("sat_still_bubbling", sbus.fifo_count, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Producer side of the pipeline's `instr` input.
- A host loads instructions through a valid/ready write port into a program FIFO.
- The unit presents one instruction per cycle to the 4-stage pipeline core. When the head instruction reads a register written by a recently issued instruction, it inserts NOP bubbles instead.
- Keeps issue/stall counters for the bench and debug.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, ≥2.
- HAZARD_WINDOW, 3, number of previous issue slots checked for RAW hazards (1..4).
- NOP_INSTR, 32'h0000_007F, word driven on idle or bubble slots; opcode 7'h7F is not a writer.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host instruction valid.
- wr_instr  in  32  host instruction word.
- wr_ready  out  1  FIFO can accept; equals (count < DEPTH), from registered count.
- run  in  1  issue enable (level).
- flush  in  1  synchronous FIFO/history clear; does not clear counters.
- instr  out  32  registered instruction to the pipeline core.
- issue_valid  out  1  instr holds a real instruction this cycle.
- bubble  out  1  instr is NOP due to a hazard stall.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- issued_count  out  16  instructions issued, saturating.
- stall_count  out  16  hazard bubbles inserted, saturating.

Behaviour:
- Reset, synchronous on rst=1:
  - FIFO empty, all history entries invalid, both counters 0.
  - instr=NOP_INSTR; issue_valid=0; bubble=0; wr_ready=1.
- Decode of the FIFO head:
  - opcode = [6:0]; rs1 = rd = [15:11]; rs2 = [20:16].
  - Writer opcodes are 0 (ADD), 1 (SUB), 2 (AND) and 4 (LOAD); every other opcode is a non-writer.
  - Register 0 is not special.
- History:
  - Shift register of HAZARD_WINDOW entries {valid, rd}, shifted every clock when not in reset or flush.
  - The new entry is valid only when this cycle issues a writer opcode.
  - Bubbles, idle slots and non-writers shift in invalid.
- Hazard: the head matches any valid history entry whose rd equals the head's rs1 or rs2.
- Per-cycle issue decision, registered, visible on outputs the next cycle:
  - IDLE: run=0 or FIFO empty. Outputs instr=NOP, issue_valid=0, bubble=0; no pop.
  - STALL: run=1, FIFO non-empty, hazard. Outputs instr=NOP, issue_valid=0, bubble=1; no pop; stall_count+1.
  - ISSUE: run=1, FIFO non-empty, no hazard. Outputs instr=head, issue_valid=1, bubble=0; pop; issued_count+1.
- Write: accepted when wr_valid && wr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, writes are refused even if a pop occurs that cycle.
  - A word written into an empty FIFO is issuable no earlier than the following cycle.
- Ordering: strict FIFO; no reordering past a stalled head.
- flush:
  - Empties the FIFO and invalidates history.
  - Next outputs are NOP, issue_valid=0, bubble=0.
  - A write in the same cycle is dropped (wr_ready is forced 0 during flush).
  - flush has priority over push and pop.
- rst asserted mid-stream discards all queued instructions; no partial issue.
- Counters saturate at 16'hFFFF; no wrap.
- Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.

Test Plan:
- Reset with wr_valid held high → during and after reset: instr=32'h7F, issue_valid=0, fifo_count=0, wr_ready=1; nothing queued on the reset cycle.
- Load 0x00011800 (ADD r3,r1), 0x00022000 (ADD r4,r2), 0x00032802 (AND r5,r3), then run=1 from slot T:
  - ADD issues at T, ADD at T+1;
  - bubble=1 at T+2 and T+3;
  - AND issues at T+4;
  - stall_count=2, issued_count=3.
- Independent stream: 16 writes of 0x0000_0000 | (k<<11) | ((k+16)<<16), k=0..15 →
  - wr_ready falls at count 16; the 17th write is refused;
  - run=1 gives 16 consecutive issue_valid cycles, in order, with zero bubbles.
- Full FIFO with simultaneous pop and wr_valid → write refused that cycle; count 16→15; the write is accepted the next cycle.
- Mid-stream flush while 5 entries are queued and a stall is pending → fifo_count=0 next cycle, instr=NOP, no further issues; counters retained.
- Saturation: force 70000 stall cycles (e.g. a self-dependent head behind a LOAD writer with HAZARD_WINDOW=4 via a repeated-hazard stub) → stall_count holds at 16'hFFFF.
